// File: rtl/matrix_add_seq_if.sv
// Stream bundle between the sequencer and its operand source / result sink.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface matrix_add_seq_if #(
    parameter int width = 16
);
    logic               s_valid;
    logic               s_ready;
    logic [2*width-1:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic [2*width-1:0] m_data;
    logic               m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/matrix_add_seq.sv
// Operand collector / result drainer wrapped around the 2x2 complex EFP matrix adder.
//
// state | meaning
// LOAD  | accept 8 operand beats (A00..A11, B00..B11), s_ready high
// START | one-cycle flag pulse to the adder, latency counter loaded
// WAIT  | count down adder latency, capture C_in at terminal count
// DRAIN | stream C00..C11 out on the valid/ready handshake
module matrix_add_seq #(
    parameter int width = 16,
    parameter int LAT   = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    matrix_add_seq_if.slave               bus,
    input  logic [4:0]                    cfg_m_bit1,
    input  logic [4:0]                    cfg_m_bit2,
    output logic [1:0][1:0][2*width-1:0]  A_out,
    output logic [1:0][1:0][2*width-1:0]  B_out,
    output logic [4:0]                    m_bit1,
    output logic [4:0]                    m_bit2,
    output logic                          flag,
    input  logic [1:0][1:0][2*width-1:0]  C_in,
    output logic                          busy
);
    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [2:0]                     beat;
    logic [3:0]                     lat_cnt;
    logic [1:0]                     idx;
    logic [1:0][1:0][2*width-1:0]   result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        flag        = 1'b0;
        busy        = 1'b1;
        case (state)
            LOAD: begin
                bus.s_ready = 1'b1;
                busy        = 1'b0;
                if (bus.s_valid && beat == 3'd7) state_nxt = START;
            end
            START: begin
                flag      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd0) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_last  = (idx == 2'd3);
                if (bus.m_ready && idx == 2'd3) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign bus.m_data = result[idx[1]][idx[0]];

    // Operands and config only move on accepted LOAD beats, so the adder sees
    // them stable from START until the next batch's first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            lat_cnt <= '0;
            idx     <= '0;
            A_out   <= '0;
            B_out   <= '0;
            m_bit1  <= '0;
            m_bit2  <= '0;
            result  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.s_valid) begin
                        if (!beat[2]) A_out[beat[1]][beat[0]] <= bus.s_data;
                        else          B_out[beat[1]][beat[0]] <= bus.s_data;
                        if (beat == 3'd0) begin
                            m_bit1 <= cfg_m_bit1;
                            m_bit2 <= cfg_m_bit2;
                        end
                        beat <= beat + 3'd1;
                    end
                end
                START: lat_cnt <= 4'(LAT - 1);
                WAIT: begin
                    if (lat_cnt == 4'd0) result  <= C_in;
                    else                 lat_cnt <= lat_cnt - 4'd1;
                end
                DRAIN: begin
                    if (bus.m_ready) idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_add_seq.sv
// Directed bench for matrix_add_seq: load, latency alignment, stalls, resets, cfg latching.
module tb_matrix_add_seq;
    localparam int width = 16;
    localparam int LAT   = 5;
    localparam int W2    = 2 * width;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_add_seq_if #(.width(width)) bus();

    logic [4:0]                 cfg_m_bit1, cfg_m_bit2, m_bit1, m_bit2;
    logic [1:0][1:0][W2-1:0]    A_out, B_out, C_in;
    logic                       flag, busy;

    matrix_add_seq #(.width(width), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cfg_m_bit1(cfg_m_bit1), .cfg_m_bit2(cfg_m_bit2),
        .A_out(A_out), .B_out(B_out), .m_bit1(m_bit1), .m_bit2(m_bit2),
        .flag(flag), .C_in(C_in), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends beats 0..stop_after-1; leaves s_valid high with junk afterwards.
    task automatic load_batch(input logic [W2-1:0] a_base, input logic [W2-1:0] b_base,
                              input logic [4:0] c1, input logic [4:0] c2,
                              input bit gaps, input int stop_after);
        for (int k = 0; k < 8; k++) begin
            if (k == stop_after) return;
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = 32'hBAD0_0000;
                    tick();
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = (k < 4) ? a_base + W2'(k) : b_base + W2'(k - 4);
            cfg_m_bit1  = (k == 0) ? c1 : ~c1;
            cfg_m_bit2  = (k == 0) ? c2 : ~c2;
            chk("s_ready_load", {63'd0, bus.s_ready}, 64'd1);
            tick();
        end
        bus.s_data = 32'hDEAD_BEEF;
    endtask

    // Entered at START; leaves the bench in the first DRAIN cycle.
    task automatic run_to_drain(input logic [1:0][1:0][W2-1:0] good, input bit pulse_only);
        logic [1:0][1:0][W2-1:0] garb;
        garb = {4{32'h0BAD_F00D}};
        chk("flag_start", {63'd0, flag}, 64'd1);
        chk("busy_start", {63'd0, busy}, 64'd1);
        chk("s_ready_start", {63'd0, bus.s_ready}, 64'd0);
        C_in = pulse_only ? garb : good;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            chk("flag_wait", {63'd0, flag}, 64'd0);
            chk("m_valid_wait", {63'd0, bus.m_valid}, 64'd0);
            chk("s_ready_wait", {63'd0, bus.s_ready}, 64'd0);
            C_in = (pulse_only && i != LAT) ? garb ^ {4{W2'(i)}} : good;
        end
        tick();
        if (pulse_only) C_in = garb;
    endtask

    task automatic drain(input logic [W2-1:0] ev [4], input bit stall);
        int got = 0;
        int cyc = 0;
        while (got < 4 && cyc < 40) begin
            bus.m_ready = stall ? (cyc % 3 == 0) : 1'b1;
            chk("m_valid_drain", {63'd0, bus.m_valid}, 64'd1);
            chk("m_data_drain", {32'd0, bus.m_data}, {32'd0, ev[got]});
            chk("m_last_drain", {63'd0, bus.m_last}, {63'd0, got == 3});
            chk("s_ready_drain", {63'd0, bus.s_ready}, 64'd0);
            if (bus.m_ready) got++;
            tick();
            cyc++;
        end
        chk("drain_count", 64'(got), 64'd4);
        bus.m_ready = 1'b0;
        chk("m_valid_after", {63'd0, bus.m_valid}, 64'd0);
        chk("s_ready_after", {63'd0, bus.s_ready}, 64'd1);
        chk("busy_after", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [W2-1:0] ev [4];
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        cfg_m_bit1  = '0;
        cfg_m_bit2  = '0;
        C_in        = '0;

        #12;
        chk("rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
        chk("rst_flag", {63'd0, flag}, 64'd0);
        chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("rst_m_last", {63'd0, bus.m_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_A", {63'd0, |A_out}, 64'd0);
        chk("rst_B", {63'd0, |B_out}, 64'd0);
        chk("rst_m_data", {32'd0, bus.m_data}, 64'd0);
        chk("rst_m_bit1", {59'd0, m_bit1}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Batch 1: placement, cfg latch, pulsed C_in proves latency alignment.
        load_batch(32'h0001_0000, 32'h0010_0000, 5'd7, 5'd3, 1'b0, 8);
        chk("A10", {32'd0, A_out[1][0]}, 64'h0001_0002);
        chk("B11", {32'd0, B_out[1][1]}, 64'h0010_0003);
        chk("m_bit1_b1", {59'd0, m_bit1}, 64'd7);
        chk("m_bit2_b1", {59'd0, m_bit2}, 64'd3);
        run_to_drain({4{32'hAAAA_5555}}, 1'b1);
        chk("A00_held", {32'd0, A_out[0][0]}, 64'h0001_0000);
        chk("B00_held", {32'd0, B_out[0][0]}, 64'h0010_0000);
        ev = '{32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555};
        drain(ev, 1'b0);
        chk("A00_after_drain", {32'd0, A_out[0][0]}, 64'h0001_0000);
        bus.s_valid = 1'b0;
        chk("m_bit1_held", {59'd0, m_bit1}, 64'd7);

        // Batch 2: gapped input, new cfg, stalled drain of 1,2,3,4.
        load_batch(32'h0000_0100, 32'h0000_0200, 5'd9, 5'd12, 1'b1, 8);
        chk("m_bit1_b2", {59'd0, m_bit1}, 64'd9);
        chk("m_bit2_b2", {59'd0, m_bit2}, 64'd12);
        chk("A01_b2", {32'd0, A_out[0][1]}, 64'h0000_0101);
        chk("A11_b2", {32'd0, A_out[1][1]}, 64'h0000_0103);
        chk("B10_b2", {32'd0, B_out[1][0]}, 64'h0000_0202);
        run_to_drain({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        ev = '{32'd1, 32'd2, 32'd3, 32'd4};
        drain(ev, 1'b1);
        bus.s_valid = 1'b0;

        // Reset after beat 5.
        load_batch(32'h0000_0300, 32'h0000_0400, 5'd5, 5'd6, 1'b0, 6);
        bus.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst5_busy", {63'd0, busy}, 64'd0);
        chk("rst5_s_ready", {63'd0, bus.s_ready}, 64'd1);
        chk("rst5_A", {63'd0, |A_out}, 64'd0);
        chk("rst5_B", {63'd0, |B_out}, 64'd0);
        chk("rst5_m_bit1", {59'd0, m_bit1}, 64'd0);
        rst_n = 1'b1;
        tick();

        load_batch(32'h0000_0500, 32'h0000_0600, 5'd1, 5'd2, 1'b0, 8);
        bus.s_valid = 1'b0;
        chk("A00_after_rst", {32'd0, A_out[0][0]}, 64'h0000_0500);
        chk("B11_after_rst", {32'd0, B_out[1][1]}, 64'h0000_0603);
        chk("m_bit1_after_rst", {59'd0, m_bit1}, 64'd1);
        run_to_drain({32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);
        bus.m_ready = 1'b1;
        tick();
        tick();
        chk("mid_drain_data", {32'd0, bus.m_data}, 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstd_m_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("rstd_m_data", {32'd0, bus.m_data}, 64'd0);
        chk("rstd_m_last", {63'd0, bus.m_last}, 64'd0);
        chk("rstd_busy", {63'd0, busy}, 64'd0);
        bus.m_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        load_batch(32'h0000_0700, 32'h0000_0800, 5'd4, 5'd4, 1'b1, 8);
        bus.s_valid = 1'b0;
        chk("flag_final", {63'd0, flag}, 64'd1);
        chk("A00_final", {32'd0, A_out[0][0]}, 64'h0000_0700);
        chk("B11_final", {32'd0, B_out[1][1]}, 64'h0000_0803);
        tick();
        chk("flag_final_drop", {63'd0, flag}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
